// File: rtl/alu_rs.sv
// alu_rs: reservation station that holds dispatched ALU instructions until both operands are known,
// snoops the ALU/LSB result buses, and issues the lowest-index ready entry once per cycle.
// Optional macro ALU_RS_FAST_WAKEUP_EN: an entry may issue in the same cycle its last operand is broadcast.
module alu_rs #(
    parameter int RS_SIZE        = 8,
    parameter int RS_SIZE_WIDTH  = 3,
    parameter int XLEN           = 32,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int ROB_SIZE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic                      flush,

    input  logic                      dec_valid,
    input  logic [ALU_OP_WIDTH-1:0]   dec_op,
    input  logic [XLEN-1:0]           dec_val1,
    input  logic [XLEN-1:0]           dec_val2,
    input  logic                      dec_dep1_valid,
    input  logic                      dec_dep2_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] dec_dep1,
    input  logic [ROB_SIZE_WIDTH-1:0] dec_dep2,
    input  logic [ROB_SIZE_WIDTH-1:0] dec_id,
    output logic                      rs_full,

    input  logic                      alu_ready,
    input  logic [XLEN-1:0]           alu_res,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
    input  logic                      lsb_ready,
    input  logic [XLEN-1:0]           lsb_res,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,

    output logic                      rs_ready,
    output logic [ALU_OP_WIDTH-1:0]   rs_op,
    output logic [XLEN-1:0]           rs_val1,
    output logic [XLEN-1:0]           rs_val2,
    output logic [ROB_SIZE_WIDTH-1:0] rs_id
);

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0]   op;
        logic [XLEN-1:0]           v1;
        logic [XLEN-1:0]           v2;
        logic                      q1_valid;
        logic [ROB_SIZE_WIDTH-1:0] q1;
        logic                      q2_valid;
        logic [ROB_SIZE_WIDTH-1:0] q2;
        logic [ROB_SIZE_WIDTH-1:0] id;
    } entry_t;

    logic [RS_SIZE-1:0]       busy;
    logic [RS_SIZE-1:0]       busy_next;
    entry_t                   entries [RS_SIZE];

    logic [RS_SIZE-1:0]       cand;
    logic                     sel_found;
    logic [RS_SIZE_WIDTH-1:0] sel_idx;
    logic                     free_found;
    logic [RS_SIZE_WIDTH-1:0] free_idx;
    logic                     accept;
    entry_t                   sel_entry;
    entry_t                   new_entry;
    logic [XLEN-1:0]          issue_val1;
    logic [XLEN-1:0]          issue_val2;

    // A tag is satisfied when either result bus carries it this cycle.
    function automatic logic bus_hit(input logic [ROB_SIZE_WIDTH-1:0] tag);
        return (alu_ready && alu_id == tag) || (lsb_ready && lsb_id == tag);
    endfunction

    // ALU wins if both buses claim the same tag; that case is illegal but kept deterministic.
    function automatic logic [XLEN-1:0] bus_val(input logic [ROB_SIZE_WIDTH-1:0] tag);
        return (alu_ready && alu_id == tag) ? alu_res : lsb_res;
    endfunction

    assign rs_full = &busy;
    assign accept  = dec_valid && free_found;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
`ifdef ALU_RS_FAST_WAKEUP_EN
            cand[i] = busy[i]
                   && (!entries[i].q1_valid || bus_hit(entries[i].q1))
                   && (!entries[i].q2_valid || bus_hit(entries[i].q2));
`else
            cand[i] = busy[i] && !entries[i].q1_valid && !entries[i].q2_valid;
`endif
        end
    end

    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = RS_SIZE_WIDTH'(i);
            end
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = RS_SIZE_WIDTH'(i);
            end
        end
    end

    always_comb begin
        sel_entry  = entries[sel_idx];
        issue_val1 = sel_entry.v1;
        issue_val2 = sel_entry.v2;
`ifdef ALU_RS_FAST_WAKEUP_EN
        if (sel_entry.q1_valid) issue_val1 = bus_val(sel_entry.q1);
        if (sel_entry.q2_valid) issue_val2 = bus_val(sel_entry.q2);
`endif
    end

    // New entry, with operands forwarded from a broadcast of the same cycle.
    always_comb begin
        new_entry.op = dec_op;
        new_entry.id = dec_id;
        new_entry.q1 = dec_dep1;
        new_entry.q2 = dec_dep2;
        if (dec_dep1_valid && bus_hit(dec_dep1)) begin
            new_entry.v1       = bus_val(dec_dep1);
            new_entry.q1_valid = 1'b0;
        end else begin
            new_entry.v1       = dec_val1;
            new_entry.q1_valid = dec_dep1_valid;
        end
        if (dec_dep2_valid && bus_hit(dec_dep2)) begin
            new_entry.v2       = bus_val(dec_dep2);
            new_entry.q2_valid = 1'b0;
        end else begin
            new_entry.v2       = dec_val2;
            new_entry.q2_valid = dec_dep2_valid;
        end
    end

    // Free slots come from registered busy, so a slot vacated by this cycle's issue is not reused yet.
    always_comb begin
        busy_next = busy;
        if (sel_found) busy_next[sel_idx] = 1'b0;
        if (accept) busy_next[free_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            rs_ready <= 1'b0;
            rs_op    <= '0;
            rs_val1  <= '0;
            rs_val2  <= '0;
            rs_id    <= '0;
        end else if (rdy) begin
            if (flush) begin
                busy     <= '0;
                rs_ready <= 1'b0;
            end else begin
                busy     <= busy_next;
                rs_ready <= sel_found;
                if (sel_found) begin
                    rs_op   <= sel_entry.op;
                    rs_val1 <= issue_val1;
                    rs_val2 <= issue_val2;
                    rs_id   <= sel_entry.id;
                end
            end
        end
    end

    // NOTE: the entry payload has no reset; it is only ever observed while its busy bit is set,
    // and keeping it out of the reset domain lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    if (entries[i].q1_valid && bus_hit(entries[i].q1)) begin
                        entries[i].v1       <= bus_val(entries[i].q1);
                        entries[i].q1_valid <= 1'b0;
                    end
                    if (entries[i].q2_valid && bus_hit(entries[i].q2)) begin
                        entries[i].v2       <= bus_val(entries[i].q2);
                        entries[i].q2_valid <= 1'b0;
                    end
                end
            end
            if (accept) entries[free_idx] <= new_entry;
        end
    end

endmodule
